// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a word-wide big-endian data memory.
// Optional feature macro: MAU_RANGE_CHECK_EN (reject accesses running past MEM_BYTES).
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        latWe;
  logic        latUnsigned;
  logic        latErr;
  logic [1:0]  latSize;
  logic [1:0]  latOff;
  logic [15:0] latWdata;
  logic [31:0] capWord;
  logic        memRd;
  logic        memWr;

  logic        reqErr;
  logic [31:0] reqWordAddr;
  logic [31:0] mergedWord;
  logic [31:0] loadData;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

`ifdef MAU_RANGE_CHECK_EN
  logic [32:0] reqEnd;
  logic [32:0] reqBytes;

  assign reqWordAddr = {req_addr[31:2], 2'b00};
`else
  localparam int unsigned AddrW = $clog2(MEM_BYTES);
  logic unusedAddrBits;

  // Without the range check the address simply wraps inside the memory.
  assign reqWordAddr    = 32'({req_addr[AddrW-1:2], 2'b00});
  assign unusedAddrBits = ^req_addr[31:AddrW];
`endif

  // Request error decode: bad size, misalignment, optionally out of range.
  always_comb begin
    reqErr = 1'b0;
    case (req_size)
      SizeByte: reqErr = 1'b0;
      SizeHalf: reqErr = req_addr[0];
      SizeWord: reqErr = (req_addr[1:0] != 2'b00);
      default:  reqErr = 1'b1;
    endcase
`ifdef MAU_RANGE_CHECK_EN
    reqBytes = (req_size == SizeByte) ? 33'd1 : (req_size == SizeHalf) ? 33'd2 : 33'd4;
    reqEnd   = {1'b0, req_addr} + reqBytes;
    if (reqEnd > 33'(MEM_BYTES)) reqErr = 1'b1;
`endif
  end

  // Sub-word store: replace the addressed big-endian lane of the word just read.
  always_comb begin
    mergedWord = MemReadData;
    if (latSize == SizeByte) begin
      case (latOff)
        2'd0:    mergedWord[31:24] = latWdata[7:0];
        2'd1:    mergedWord[23:16] = latWdata[7:0];
        2'd2:    mergedWord[15:8]  = latWdata[7:0];
        default: mergedWord[7:0]   = latWdata[7:0];
      endcase
    end else if (latOff[1]) begin
      mergedWord[15:0] = latWdata;
    end else begin
      mergedWord[31:16] = latWdata;
    end
  end

  // Load alignment and extension from the captured word.
  always_comb begin
    case (latOff)
      2'd0:    laneByte = capWord[31:24];
      2'd1:    laneByte = capWord[23:16];
      2'd2:    laneByte = capWord[15:8];
      default: laneByte = capWord[7:0];
    endcase
    laneHalf = latOff[1] ? capWord[15:0] : capWord[31:16];
    case (latSize)
      SizeByte: loadData = latUnsigned ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
      SizeHalf: loadData = latUnsigned ? {16'h0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
      default:  loadData = capWord;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_err     <= 1'b0;
      memRd        <= 1'b0;
      memWr        <= 1'b0;
      MemAddr      <= 32'h0;
      MemWriteData <= 32'h0;
      latWe        <= 1'b0;
      latUnsigned  <= 1'b0;
      latErr       <= 1'b0;
      latSize      <= SizeByte;
      latOff       <= 2'b00;
      latWdata     <= 16'h0;
      capWord      <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            latWe       <= req_we;
            latUnsigned <= req_unsigned;
            latErr      <= reqErr;
            latSize     <= req_size;
            latOff      <= req_addr[1:0];
            latWdata    <= req_wdata[15:0];
            if (reqErr) begin
              state <= RESP;
            end else if (req_we && (req_size == SizeWord)) begin
              state        <= WRITE;
              memWr        <= 1'b1;
              MemAddr      <= reqWordAddr;
              MemWriteData <= req_wdata;
            end else begin
              state   <= READ;
              memRd   <= 1'b1;
              MemAddr <= reqWordAddr;
            end
          end
        end
        READ: begin
          capWord <= MemReadData;
          memRd   <= 1'b0;
          if (latWe) begin
            state        <= WRITE;
            memWr        <= 1'b1;
            MemWriteData <= mergedWord;
          end else begin
            state   <= RESP;
            MemAddr <= 32'h0;
          end
        end
        WRITE: begin
          memWr        <= 1'b0;
          MemAddr      <= 32'h0;
          MemWriteData <= 32'h0;
          state        <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= latErr;
          resp_rdata <= (latErr || latWe) ? 32'h0 : loadData;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset must kill handshakes and memory strobes within the same cycle.
  assign req_ready = (state == IDLE) && !rst;
  assign MemRead   = memRd && !rst;
  assign MemWrite  = memWr && !rst;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, giving the data memory size in bytes.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: CPU access request.
REQ-005 SHALL have port req_ready, output, 1: the unit accepts a request.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word; 11 flagged as error.
REQ-008 SHALL have port req_unsigned, input, 1: zero-extend loads.
REQ-009 SHALL have ports req_addr, input, 32 (byte address) and req_wdata, input, 32 (store data, right-aligned).
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have ports resp_rdata, output, 32 (load result) and resp_err, output, 1 (access rejected).
REQ-012 SHALL have ports MemAddr, output, 32; MemWriteData, output, 32; MemWrite, output, 1; MemRead, output, 1; MemReadData, input, 32, all toward the data memory.

Function
REQ-013 The memory side SHALL be treated as word wide and big-endian: byte offset 0 maps to bits [31:24], offset 3 to [7:0]; the memory reads combinationally and writes on negedge when MemWrite=1.
REQ-014 The unit SHALL have states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE and only when rst=0.
REQ-015 On req_valid&&req_ready, the unit SHALL latch all req_* fields; it SHALL ignore CPU inputs outside IDLE.
REQ-016 Error conditions: size 11; half with addr[0]=1; word with addr[1:0]!=0. On error, IDLE SHALL go to RESP with no memory access.
REQ-017 Load path: IDLE->READ->RESP. READ SHALL drive MemRead=1 and MemAddr=addr&~3, and SHALL capture MemReadData at the end of the cycle.
REQ-018 Word store path: IDLE->WRITE->RESP. WRITE SHALL drive MemAddr=addr&~3, MemWriteData=wdata, MemWrite=1.
REQ-019 Sub-word store path: IDLE->READ->WRITE->RESP. WRITE SHALL drive the captured word with only the addressed byte or half replaced by wdata[7:0] or wdata[15:0].
REQ-020 Latency from the accept edge SHALL be: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
REQ-021 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-022 Loads SHALL right-align the addressed lane into resp_rdata and sign-extend it unless req_unsigned=1; a word load SHALL return the full word.
REQ-023 resp_rdata and resp_err SHALL hold their values until the next RESP; a store response SHALL return resp_rdata=0.
REQ-024 Outside READ/WRITE, MemRead and MemWrite SHALL be 0; MemAddr and MemWriteData SHALL be 0 in IDLE.
REQ-025 MemWrite SHALL be gated combinationally with !rst, so a write in progress during the cycle rst is high is suppressed.

Reset
REQ-026 On posedge clk with rst=1, the unit SHALL set state=IDLE and resp_valid=0, resp_rdata=0, resp_err=0; any pending request is dropped with no response.
REQ-027 While rst=1, req_ready, MemRead and MemWrite SHALL be 0.

Configuration
REQ-028 Macro MAU_RANGE_CHECK_EN defined: any access with addr+bytes > MEM_BYTES SHALL be an error (REQ-016 path). Macro undefined: no range check, and MemAddr SHALL use only addr bits [$clog2(MEM_BYTES)-1:0] with the upper bits zero.

Verification
REQ-029 Store word 0x11223344 at 0x10, then load word from 0x10 -> resp_rdata=0x11223344, resp_err=0, resp_valid 2 cycles after each accept.
REQ-030 Then sb 0xAB at 0x12, and load word from 0x10 -> 0x1122AB44; store latency 3 cycles; exactly one MemWrite cycle.
REQ-031 Load byte at 0x12 signed -> 0xFFFFFFAB; unsigned -> 0x000000AB; load half at 0x12 signed -> 0xFFFFAB44.
REQ-032 Load half at 0x11 -> resp_err=1 one cycle after accept, no MemRead/MemWrite pulse; req_size=11 -> resp_err=1.
REQ-033 With MAU_RANGE_CHECK_EN, load word at 0x7C -> OK and at 0x80 -> resp_err=1; without it, 0x80 accesses address 0x00.
REQ-034 Assert rst during WRITE of sw 0xDEADBEEF at 0x20 -> no memory change at 0x20, state IDLE, resp_valid never pulses.
